// File: rtl/seven_seg_ascii_capture.sv
// Loopback receiver for a multiplexed active-low 7-segment bus: samples each settled
// digit once per dwell, decodes it back to ASCII and emits whole frames with a strobe.
module seven_seg_ascii_capture #(
  parameter int DISPLAY_COUNT = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  segments,
  input  logic [7:0]  enable,
  output logic [63:0] values,
  output logic        frame_valid,
  output logic        frame_bad
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_W = CW'(SETTLE_CYCLES);

  logic [7:0]    count_mask;
  logic [7:0]    sel;
  logic          sel_valid;
  logic          same_enable;
  logic [2:0]    sel_idx;
  logic          capture;
  logic          complete;
  logic [7:0]    dec_char;
  logic          dec_bad;
  logic [7:0]    enable_prev_reg;
  logic [CW-1:0] dwell_reg, dwell_next;
  logic [7:0]    seen_reg, seen_next;
  logic [63:0]   buffer_reg, buffer_next, frame_next;
  logic          bad_acc_reg;
  logic [63:0]   values_reg;
  logic          frame_valid_reg, frame_bad_reg;

  assign sel         = ~enable;
  assign same_enable = (enable == enable_prev_reg);
  // Exactly one digit selected, and that digit must be one we actually scan.
  assign sel_valid   = (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0)
                       && ((sel & ~count_mask) == 8'd0);

  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) sel_idx = 3'(i);
    end
  end

  always_comb begin
    dwell_next = '0;
    if (sel_valid) begin
      if (!same_enable)               dwell_next = CW'(1);
      else if (dwell_reg == SETTLE_W) dwell_next = SETTLE_W;
      else                            dwell_next = dwell_reg + 1'b1;
    end
  end

  // A saturated counter on an unchanged enable must not re-trigger the capture.
  assign capture  = sel_valid && (dwell_next == SETTLE_W)
                    && !(same_enable && (dwell_reg == SETTLE_W));
  assign seen_next = seen_reg | (capture ? (8'd1 << sel_idx) : 8'd0);
  assign complete  = capture && ((seen_next & count_mask) == count_mask);

  // Inverse of the shared encoder; shared patterns resolve to the lowest code.
  always_comb begin
    dec_bad = 1'b0;
    case (segments)
      7'h7F:   dec_char = 8'h00;
      7'h3F:   dec_char = 8'h2D;
      7'h40:   dec_char = 8'h30;
      7'h79:   dec_char = 8'h31;
      7'h24:   dec_char = 8'h32;
      7'h30:   dec_char = 8'h33;
      7'h19:   dec_char = 8'h34;
      7'h12:   dec_char = 8'h35;
      7'h02:   dec_char = 8'h36;
      7'h78:   dec_char = 8'h37;
      7'h00:   dec_char = 8'h38;
      7'h10:   dec_char = 8'h39;
      7'h08:   dec_char = 8'h41;
      7'h03:   dec_char = 8'h42;
      7'h46:   dec_char = 8'h43;
      7'h21:   dec_char = 8'h44;
      7'h06:   dec_char = 8'h45;
      7'h0E:   dec_char = 8'h46;
      7'h09:   dec_char = 8'h48;
      7'h47:   dec_char = 8'h4C;
      7'h0C:   dec_char = 8'h50;
      7'h41:   dec_char = 8'h55;
      default: begin
        dec_char = 8'h3F;
        dec_bad  = 1'b1;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_byte
      assign count_mask[gi] = (gi < DISPLAY_COUNT);
      assign buffer_next[gi*8 +: 8] = (capture && (sel_idx == 3'(gi))) ? dec_char
                                                                        : buffer_reg[gi*8 +: 8];
      assign frame_next[gi*8 +: 8]  = count_mask[gi] ? buffer_next[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_prev_reg <= 8'hFF;
      dwell_reg       <= '0;
      seen_reg        <= 8'd0;
      buffer_reg      <= 64'd0;
      bad_acc_reg     <= 1'b0;
      values_reg      <= 64'd0;
      frame_valid_reg <= 1'b0;
      frame_bad_reg   <= 1'b0;
    end else begin
      enable_prev_reg <= enable;
      dwell_reg       <= dwell_next;
      buffer_reg      <= buffer_next;
      frame_valid_reg <= complete;
      frame_bad_reg   <= complete && (bad_acc_reg || dec_bad);
      if (complete) begin
        values_reg  <= frame_next;
        seen_reg    <= 8'd0;
        bad_acc_reg <= 1'b0;
      end else if (capture) begin
        seen_reg    <= seen_next;
        bad_acc_reg <= bad_acc_reg | dec_bad;
      end
    end
  end

  assign values      = values_reg;
  assign frame_valid = frame_valid_reg;
  assign frame_bad   = frame_bad_reg;

endmodule

// File: tb/tb_seven_seg_ascii_capture.sv
// Scoreboard bench: three capture instances (default, 4 digits, settle of 1) share one
// randomized segment bus; a dwell-level reference model predicts every frame.
module tb_seven_seg_ascii_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  segments;
  logic [7:0]  enable;
  logic [63:0] vals [3];
  logic        fv   [3];
  logic        fb   [3];

  int cnt    [3] = '{8, 4, 8};
  int settle [3] = '{4, 4, 1};

  seven_seg_ascii_capture dut_def (
    .clk(clk), .reset(reset), .segments(segments), .enable(enable),
    .values(vals[0]), .frame_valid(fv[0]), .frame_bad(fb[0]));

  seven_seg_ascii_capture #(.DISPLAY_COUNT(4), .SETTLE_CYCLES(4)) dut_dc4 (
    .clk(clk), .reset(reset), .segments(segments), .enable(enable),
    .values(vals[1]), .frame_valid(fv[1]), .frame_bad(fb[1]));

  seven_seg_ascii_capture #(.DISPLAY_COUNT(8), .SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .reset(reset), .segments(segments), .enable(enable),
    .values(vals[2]), .frame_valid(fv[2]), .frame_bad(fb[2]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  // Forward encoder table (ASCII -> active-low segments); decode is derived by search.
  byte        chars [23] = '{8'h2D, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                             8'h37, 8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45,
                             8'h46, 8'h48, 8'h4C, 8'h4F, 8'h50, 8'h53, 8'h55};
  logic [6:0] pats  [23] = '{7'h3F, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                             7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06,
                             7'h0E, 7'h09, 7'h47, 7'h40, 7'h0C, 7'h12, 7'h41};
  logic [6:0] enc_pat [128];
  bit         enc_has [128];
  logic [6:0] pat1 [8] = '{7'h24, 7'h79, 7'h24, 7'h40, 7'h47, 7'h06, 7'h7F, 7'h7F};

  typedef struct {
    int          inst;
    int          cyc;
    logic [63:0] vals;
    bit          bad;
  } exp_t;
  exp_t q[$];

  logic [7:0]  m_buf  [3][8];
  logic [7:0]  m_seen [3];
  bit          m_bad  [3];
  logic [63:0] cur_exp [3] = '{default: 64'd0};
  logic [6:0]  dwell_segs[$];
  logic [7:0]  prev_e = 8'hFF;

  function automatic logic [8:0] ref_decode(input logic [6:0] p);
    if (p == 7'h7F) return 9'h000;
    for (int c = 0; c < 128; c++)
      if (enc_has[c] && enc_pat[c] == p) return {1'b0, 8'(c)};
    return {1'b1, 8'h3F};
  endfunction

  function automatic logic [6:0] rand_seg();
    int r;
    r = $urandom_range(0, 11);
    if (r < 8)  return pats[$urandom_range(0, 22)];
    if (r < 10) return 7'h7F;
    return 7'($urandom);
  endfunction

  task automatic model_capture(input int i, input int d, input logic [6:0] p, input int at);
    logic [8:0]  r;
    logic [63:0] v;
    bit          full;
    exp_t        e;
    r = ref_decode(p);
    m_buf[i][d]  = r[7:0];
    m_seen[i][d] = 1'b1;
    m_bad[i]     = m_bad[i] | r[8];
    full = 1'b1;
    for (int k = 0; k < cnt[i]; k++) if (!m_seen[i][k]) full = 1'b0;
    if (full) begin
      v = 64'd0;
      for (int k = 0; k < cnt[i]; k++) v[k*8 +: 8] = m_buf[i][k];
      e.inst = i; e.cyc = at; e.vals = v; e.bad = m_bad[i];
      q.push_back(e);
      m_seen[i] = 8'd0;
      m_bad[i]  = 1'b0;
    end
  endtask

  // A dwell captures only if exactly one in-range digit is low for at least settle edges.
  task automatic model_dwell(input logic [7:0] e, input int start);
    logic [7:0] s;
    int d;
    s = ~e;
    if ($countones(s) == 1) begin
      d = 0;
      for (int k = 0; k < 8; k++) if (s[k]) d = k;
      for (int i = 0; i < 3; i++)
        if (d < cnt[i] && dwell_segs.size() >= settle[i])
          model_capture(i, d, dwell_segs[settle[i]-1], start + settle[i] - 1);
    end
  endtask

  task automatic drive_dwell(input logic [7:0] e, input int len, input bit rnd,
                             input logic [6:0] fixed);
    if (e == prev_e && e != 8'h00) begin
      @(negedge clk);
      enable   = 8'h00;
      segments = rand_seg();
    end
    dwell_segs = {};
    for (int j = 0; j < len; j++) dwell_segs.push_back(rnd ? rand_seg() : fixed);
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      enable   = e;
      segments = dwell_segs[j];
      if (j == 0) model_dwell(e, cyc + 1);
    end
    prev_e = e;
  endtask

  task automatic scan(input int lo, input int hi, input int len, input int bad_digit);
    for (int d = lo; d <= hi; d++)
      drive_dwell(~(8'd1 << d), len, 1'b0, (d == bad_digit) ? 7'h7E : pat1[d]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset  = 1'b0;
    enable = 8'hFF;
    prev_e = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      m_seen[i]  = 8'd0;
      m_bad[i]   = 1'b0;
      cur_exp[i] = 64'd0;
    end
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: every frame strobe must match a queued prediction at the predicted cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (fv[i]) begin
        int hit;
        hit = -1;
        for (int k = 0; k < q.size(); k++)
          if (hit < 0 && q[k].inst == i && q[k].cyc == cyc) hit = k;
        n_total++;
        if (hit < 0) begin
          n_bad++;
          $display("FAIL unexpected_frame inst=%0d cyc=%0d got values=%h", i, cyc, vals[i]);
        end else begin
          n_total += 2;
          if (vals[i] !== q[hit].vals) begin
            n_bad++;
            $display("FAIL frame_values inst=%0d got=%h want=%h", i, vals[i], q[hit].vals);
          end
          if (fb[i] !== q[hit].bad) begin
            n_bad++;
            $display("FAIL frame_bad inst=%0d got=%b want=%b", i, fb[i], q[hit].bad);
          end
          cur_exp[i] = q[hit].vals;
          q.delete(hit);
        end
      end else begin
        n_total += 2;
        if (fb[i] !== 1'b0) begin
          n_bad++;
          $display("FAIL bad_without_valid inst=%0d got=%b want=0", i, fb[i]);
        end
        if (vals[i] !== cur_exp[i]) begin
          n_bad++;
          $display("FAIL values_hold inst=%0d got=%h want=%h", i, vals[i], cur_exp[i]);
        end
      end
    end
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (q[k].cyc <= cyc) begin
        n_total++;
        n_bad++;
        $display("FAIL missing_frame inst=%0d got=none want=%h at cyc %0d",
                 q[k].inst, q[k].vals, q[k].cyc);
        q.delete(k);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] e;
    int r, len;
    for (int k = 0; k < 23; k++) begin
      enc_has[chars[k]] = 1'b1;
      enc_pat[chars[k]] = pats[k];
    end
    for (int i = 0; i < 3; i++) begin
      m_seen[i] = 8'd0;
      m_bad[i]  = 1'b0;
    end
    reset = 1'b0; enable = 8'hFF; segments = 7'h7F;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;

    for (int d = 0; d < 8; d++) drive_dwell(~(8'd1 << d), 3, 1'b1, 7'h00);
    @(negedge clk); #2 check("short_dwell_values", vals[0], 64'd0);
    drive_dwell(8'hFB, 1000, 1'b1, 7'h00);

    do_reset();
    scan(0, 7, 6, -1);
    @(negedge clk); #2 check("scan_values", vals[0], 64'h0000_454C_3032_3132);
    check("scan_values_dc4", vals[1], 64'h0000_0000_3032_3132);

    for (int d = 7; d >= 0; d--) begin
      drive_dwell(8'hFF, 2, 1'b1, 7'h00);
      if (d == 4) drive_dwell(8'hFC, 10, 1'b1, 7'h00);
      drive_dwell(~(8'd1 << d), 5, 1'b0, pat1[d]);
    end
    @(negedge clk); #2 check("blanked_scan_values", vals[0], 64'h0000_454C_3032_3132);

    scan(0, 7, 4, 3);
    @(negedge clk); #2 check("bad_digit_byte3", {56'd0, vals[0][31:24]}, 64'h3F);
    scan(0, 7, 4, -1);

    drive_dwell(8'hFE, 4, 1'b1, 7'h00);
    drive_dwell(8'hFD, 4, 1'b1, 7'h00);
    drive_dwell(8'h7F, 4, 1'b1, 7'h00);
    drive_dwell(8'hFB, 4, 1'b1, 7'h00);
    drive_dwell(8'hF7, 4, 1'b1, 7'h00);
    @(negedge clk); #2 check("dc4_upper_zero", {32'd0, vals[1][63:32]}, 64'd0);

    do_reset();
    scan(0, 5, 5, -1);
    do_reset();
    scan(6, 7, 5, -1);
    @(negedge clk); #2 check("partial_after_reset", vals[0], 64'd0);
    scan(0, 7, 5, -1);
    @(negedge clk); #2 check("rescan_values", vals[0], 64'h0000_454C_3032_3132);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       e = ~(8'd1 << $urandom_range(0, 7));
      else if (r == 6) e = 8'hFF;
      else if (r == 7) e = ~((8'd1 << $urandom_range(0, 3)) | (8'd1 << $urandom_range(4, 7)));
      else             e = 8'($urandom);
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 6);
      drive_dwell(e, len, 1'b1, 7'h00);
      if (n == 150) do_reset();
    end

    repeat (6) @(negedge clk);
    #2 check("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_ascii_capture.md
Name: seven_seg_ascii_capture

Overview:
- Receive-side counterpart of seven_seg_display_ascii.
- Watches a multiplexed 7-segment bus (segments and digit enables, both active-low), samples each digit once per dwell, and decodes the segment pattern back to ASCII.
- Reassembles the 64-bit character string and presents it with a one-cycle frame strobe.
- Used in loopback self-test tops and benches to check display drivers end to end.

Parameters:
- DISPLAY_COUNT, 8, number of digits scanned (1..8); enable bits at or above this index are out of range.
- SETTLE_CYCLES, 4, consecutive cycles an enable value must hold before its segments are sampled (>=1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- segments  input  7  segment bus, active-low; bit0=a ... bit6=g.
- enable  input  8  digit enables, active-low; enable[i] low selects digit i (digit 0 rightmost).
- values  output  64  last complete frame; byte i (values[8i+7:8i]) = ASCII of digit i.
- frame_valid  output  1  one-cycle pulse when values is updated.
- frame_bad  output  1  valid with frame_valid; 1 if any digit in the frame failed to decode.

Behaviour:
- Reset (reset low, async): values=0, frame_valid=0, frame_bad=0, dwell counter=0, seen mask=0, buffer=0, bad accumulator=0. Reset mid-frame discards the partial frame.
- Valid enable: exactly one bit low, and its index is < DISPLAY_COUNT. Any other value is invalid (all-high blanking, multiple lows, out-of-range index). An invalid enable clears the dwell counter and captures nothing.
- Dwell counter:
  - An edge where enable is valid and equals its value at the previous edge increments the counter, saturating at SETTLE_CYCLES.
  - A change to a new valid value loads 1.
- Capture edge: the edge at which the counter reaches SETTLE_CYCLES, i.e. the SETTLE_CYCLES-th consecutive edge with the same valid enable.
  - segments is sampled at exactly that edge; values seen earlier in the dwell are ignored.
  - Exactly one capture per dwell, however long the dwell lasts.
  - SETTLE_CYCLES=1 captures on the first edge of each new valid value.
- Decode (combinational from segments):
  - Table is the exact inverse of the shared ASCII-to-segment encoder.
  - Where several codes share a pattern, the lowest ASCII code wins (e.g. '0'/'O' -> 8'h30).
  - 7'h7F (all off) -> 8'h00.
  - Any unlisted pattern -> 8'h3F ('?') and sets the bad accumulator.
- Capture writes the decoded byte into buffer byte i and sets seen[i]. A repeated capture of the same digit before frame completion overwrites the byte.
- Frame completion: when the capture makes seen[DISPLAY_COUNT-1:0] all ones, at that same edge:
  - values <= assembled buffer, with bytes >= DISPLAY_COUNT forced to 0;
  - frame_valid <= 1 for one cycle;
  - frame_bad <= bad accumulator OR this capture's error;
  - seen <= 0 and bad accumulator <= 0.
- values holds between frames. frame_bad is 0 whenever frame_valid is 0.
- Scan order is irrelevant; only full coverage of digits 0..DISPLAY_COUNT-1 completes a frame.
- Latency: values and frame_valid are visible immediately after the capture edge of the final missing digit.

Test Plan:
- Defaults. Scan digits 0..7 with dwell 6 and patterns digit0 '2'=7'h24, 1 '1'=7'h79, 2 '2'=7'h24, 3 'O'=7'h40, 4 'L'=7'h47, 5 'E'=7'h06, 6 and 7 blank=7'h7F -> frame_valid pulses once, values=64'h0000_454C_3032_3132, frame_bad=0.
- Dwell of 3 cycles (SETTLE_CYCLES=4) on every digit -> no captures, frame_valid never asserts, values stays 0. Dwell of 1000 cycles on one digit -> exactly one capture.
- Insert enable=8'hFF between digits, and enable=8'hFC held for 10 cycles -> neither is captured; valid digits still complete the frame with correct values.
- Digit 3 driven with 7'h7E (unknown) -> byte 3 = 8'h3F and frame_bad=1 with frame_valid. Next clean frame -> frame_bad=0.
- DISPLAY_COUNT=4: scan enables 8'hFE..8'hF7 plus 8'h7F -> enable 8'h7F is ignored, frame completes after digits 0..3, values[63:32]=0.
- Assert reset after digits 0..5 are captured, release, then scan digits 6..7 only -> no frame_valid. A full rescan then produces the correct frame.
